// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver for the matrix-multiplier host link. Frames are 1 start
//   bit, 8 data bits sent LSB first, and 1 stop bit. Each bit is sampled once,
//   at mid-bit. A good byte is shown on data_out with a one-cycle rx_valid
//   pulse. A stop bit sampled low gives a one-cycle frame_err pulse, and the
//   byte is dropped.
//
// Ports
//   clk        system clock; all logic runs on the rising edge
//   reset_n    asynchronous active-low reset
//   rx         serial input, idle high, asynchronous to clk
//   data_out   last good byte; holds until the next good frame
//   rx_valid   1-cycle pulse: data_out was updated this cycle
//   rx_busy    high whenever the receiver is not in IDLE
//   frame_err  1-cycle pulse: stop bit sampled low, byte discarded
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err
);

    // CLKS_PER_BIT must be at least 4 so that the half-bit point and the
    // last-count point are distinct.
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = (CLKS_PER_BIT - 1) / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);

    typedef enum logic [2:0] {
        S_WAIT_IDLE = 3'd0,
        S_IDLE      = 3'd1,
        S_START     = 3'd2,
        S_DATA      = 3'd3,
        S_STOP      = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic             rx_meta_reg, rx_s_reg;
    logic [CNT_W-1:0] clk_cnt_reg, clk_cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg;
    logic [7:0]       data_out_reg;
    logic             rx_valid_reg, frame_err_reg;

    logic             cnt_last;
    logic             cnt_half;
    logic             bit_sample;
    logic             valid_next;
    logic             err_next;

    assign cnt_last = (clk_cnt_reg == CNT_LAST);
    assign cnt_half = (clk_cnt_reg == CNT_HALF);

    // Two-flop synchroniser. It resets to the idle level so that reset
    // cannot look like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_WAIT_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_WAIT_IDLE: if (rx_s_reg) state_next = S_IDLE;
            S_IDLE:      if (!rx_s_reg) state_next = S_START;
            // A start bit that is high again at its mid-point is a glitch.
            S_START:     if (cnt_half) state_next = rx_s_reg ? S_IDLE : S_DATA;
            S_DATA:      if (cnt_last && (bit_idx_reg == 3'd7)) state_next = S_STOP;
            // Returning to IDLE at mid-stop lets a back-to-back start bit be
            // caught. After a framing error the line may still be low (break),
            // so we wait for it to go high first.
            S_STOP:      if (cnt_last) state_next = rx_s_reg ? S_IDLE : S_WAIT_IDLE;
            default:     state_next = S_WAIT_IDLE;
        endcase
    end

    // Output and strobe decode
    always_comb begin
        rx_busy    = (state_reg != S_IDLE);
        bit_sample = (state_reg == S_DATA) && cnt_last;
        valid_next = (state_reg == S_STOP) && cnt_last && rx_s_reg;
        err_next   = (state_reg == S_STOP) && cnt_last && !rx_s_reg;
    end

    // Bit-period counter and bit index
    always_comb begin
        clk_cnt_next = '0;
        bit_idx_next = bit_idx_reg;
        case (state_reg)
            S_START: begin
                clk_cnt_next = cnt_half ? '0 : clk_cnt_reg + CNT_W'(1);
                bit_idx_next = 3'd0;
            end
            S_DATA: begin
                clk_cnt_next = cnt_last ? '0 : clk_cnt_reg + CNT_W'(1);
                if (cnt_last) bit_idx_next = bit_idx_reg + 3'd1;
            end
            S_STOP: begin
                clk_cnt_next = cnt_last ? '0 : clk_cnt_reg + CNT_W'(1);
            end
            default: begin
                clk_cnt_next = '0;
                bit_idx_next = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_cnt_reg <= '0;
            bit_idx_reg <= 3'd0;
        end else begin
            clk_cnt_reg <= clk_cnt_next;
            bit_idx_reg <= bit_idx_next;
        end
    end

    // Each shift-register bit loads only when its own index is sampled.
    // This puts data into place LSB first without a shift chain.
    for (genvar gi = 0; gi < 8; gi++) begin : g_shift
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                shift_reg[gi] <= 1'b0;
            end else if (bit_sample && (bit_idx_reg == 3'(gi))) begin
                shift_reg[gi] <= rx_s_reg;
            end
        end
    end

    // The output byte and strobes are registered, so rx_valid lines up with
    // the cycle in which the new data_out value first appears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_reg  <= 8'h00;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            if (valid_next) data_out_reg <= shift_reg;
            rx_valid_reg  <= valid_next;
            frame_err_reg <= err_next;
        end
    end

    assign data_out  = data_out_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Drives 8N1 frames bit by bit onto rx at 434 clk/bit. A monitor records
//   every rx_valid byte and every frame_err pulse. Expected bytes come from
//   the frames the bench itself builds.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 434;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    int         cyc = 0;
    logic [7:0] got_q[$];
    int         got_cyc = 0;
    int         err_pulses = 0;
    int         overlap = 0;
    logic [7:0] last_good = 8'h00;
    logic       mid_busy;

    uart_rx #(
        .CLK_FREQ (50_000_000),
        .BAUD_RATE(115_200)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx       (rx),
        .data_out (data_out),
        .rx_valid (rx_valid),
        .rx_busy  (rx_busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sample outputs on the falling edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            got_q.push_back(data_out);
            got_cyc = cyc;
        end
        if (frame_err) err_pulses++;
        if (rx_valid && frame_err) overlap++;
    end

    // Watchdog
    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_bits(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Sends one frame with the given stop level (starting on a negedge).
    // It returns at the end of the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bits(1'b0, CPB);
        for (int i = 0; i < 8; i++) begin
            drive_bits(b[i], CPB);
            if (i == 3) mid_busy = rx_busy;
        end
        drive_bits(stop, CPB);
        rx = 1'b1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        err_pulses = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rx_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", rx_busy); end
        checks++;
        if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_out); end
        checks++;
        if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_strobes: got valid=%b err=%b want 0 0", rx_valid, frame_err);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", rx_busy); end
        checks++;
        if (data_out !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL post_reset_outs: got data=%h valid=%b err=%b want 00 0 0", data_out, rx_valid, frame_err);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        int t0;
        @(negedge clk);
        clear_mon();
        t0 = cyc;
        send_frame(8'h55, 1'b1);
        last_good = 8'h55;
        repeat (4) @(negedge clk);
        checks++;
        if (got_q.size() !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
        else begin
            checks++;
            if (got_q[0] !== 8'h55) begin errors++; $display("FAIL single_data: got %h want 55", got_q[0]); end
        end
        checks++;
        if (err_pulses !== 0) begin errors++; $display("FAIL single_ferr: got %0d want 0", err_pulses); end
        checks++;
        if (got_cyc - t0 < 4110 || got_cyc - t0 > 4140) begin
            errors++; $display("FAIL single_latency: got %0d want 4110..4140", got_cyc - t0);
        end
        checks++;
        if (mid_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", mid_busy); end
        $display("frame 55 rx=%0d latency=%0d", got_q.size(), got_cyc - t0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        clear_mon();
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        last_good = 8'h3C;
        repeat (4) @(negedge clk);
        checks++;
        if (got_q.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", got_q.size()); end
        else begin
            checks++;
            if (got_q[0] !== 8'hA5 || got_q[1] !== 8'h3C) begin
                errors++; $display("FAIL b2b_data: got %h %h want a5 3c", got_q[0], got_q[1]);
            end
        end
        checks++;
        if (data_out !== 8'h3C) begin errors++; $display("FAIL b2b_hold: got %h want 3c", data_out); end
        $display("back_to_back rx=%0d", got_q.size());
    endtask

    task automatic test_framing();
        @(negedge clk);
        clear_mon();
        drive_bits(1'b0, CPB);
        drive_bits(1'b1, 8 * CPB);
        drive_bits(1'b0, 2 * CPB);
        drive_bits(1'b1, CPB);
        checks++;
        if (err_pulses !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d want 1", err_pulses); end
        checks++;
        if (got_q.size() !== 0) begin errors++; $display("FAIL ferr_novalid: got %0d want 0", got_q.size()); end
        checks++;
        if (data_out !== last_good) begin errors++; $display("FAIL ferr_hold: got %h want %h", data_out, last_good); end
        send_frame(8'h12, 1'b1);
        last_good = 8'h12;
        repeat (4) @(negedge clk);
        checks++;
        if (got_q.size() !== 1 || data_out !== 8'h12) begin
            errors++; $display("FAIL ferr_recover: got n=%0d data=%h want 1 12", got_q.size(), data_out);
        end
        $display("framing err_pulses=%0d then rx=%0d", err_pulses, got_q.size());
    endtask

    task automatic test_glitch();
        @(negedge clk);
        clear_mon();
        drive_bits(1'b0, 100);
        drive_bits(1'b1, 500);
        checks++;
        if (got_q.size() !== 0 || err_pulses !== 0) begin
            errors++; $display("FAIL glitch_out: got valid=%0d err=%0d want 0 0", got_q.size(), err_pulses);
        end
        checks++;
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got busy=%b want 0", rx_busy); end
        $display("glitch busy=%b", rx_busy);
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'h77;
        @(negedge clk);
        clear_mon();
        drive_bits(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bits(b[i], CPB);
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (data_out !== 8'h00 || rx_busy !== 1'b1) begin
            errors++; $display("FAIL midreset_state: got data=%h busy=%b want 00 1", data_out, rx_busy);
        end
        reset_n = 1'b1;
        drive_bits(1'b1, CPB);
        send_frame(8'h81, 1'b1);
        last_good = 8'h81;
        repeat (4) @(negedge clk);
        checks++;
        if (got_q.size() !== 1 || err_pulses !== 0) begin
            errors++; $display("FAIL midreset_count: got valid=%0d err=%0d want 1 0", got_q.size(), err_pulses);
        end else begin
            checks++;
            if (got_q[0] !== 8'h81) begin errors++; $display("FAIL midreset_data: got %h want 81", got_q[0]); end
        end
        $display("reset_mid rx=%0d", got_q.size());
    endtask

    // Random bytes with random gaps and occasional bad stop bits.
    // Reference: the byte queue of good frames, plus a count of bad ones.
    task automatic test_random();
        logic [7:0] exp_q[$];
        int         exp_err;
        logic [7:0] b;
        logic       bad;
        int         gap;
        exp_err = 0;
        @(negedge clk);
        clear_mon();
        for (int n = 0; n < 5; n++) begin
            b   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 3) == 0);
            gap = $urandom_range(0, 2) * CPB + $urandom_range(0, 50);
            if (bad) begin
                exp_err++;
                gap = gap + CPB;
            end else begin
                exp_q.push_back(b);
                last_good = b;
            end
            send_frame(b, !bad);
            if (gap > 0) drive_bits(1'b1, gap);
            $display("random frame %0d byte=%h stop_ok=%b gap=%0d", n, b, !bad, gap);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL rand_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (err_pulses !== exp_err) begin errors++; $display("FAIL rand_ferr: got %0d want %0d", err_pulses, exp_err); end
        checks++;
        if (data_out !== last_good) begin errors++; $display("FAIL rand_hold: got %h want %h", data_out, last_good); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_framing();
        test_glitch();
        test_reset_mid();
        test_random();
        checks++;
        if (overlap !== 0) begin errors++; $display("FAIL overlap: got %0d cycles want 0", overlap); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
